// File: rtl/phase_timer_pkg.sv
// Shared FSM states, reset-default phase durations and width helpers for phase_timer.
package phase_timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StExpire
    } state_e;

    localparam int unsigned DefaultDur0     = 2;
    localparam int unsigned DefaultDur1Even = 13;
    localparam int unsigned DefaultDur1Odd  = 5;
    localparam int unsigned DefaultDur2     = 2;
    localparam int unsigned DefaultDur3     = 1;
    localparam int unsigned DefaultDur4     = 1;

    // Index width for n entries; never zero so a single-entry table still has a port.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    function automatic bit in_range(int unsigned idx, int unsigned n);
        return idx < n;
    endfunction

    function automatic int unsigned saturate(int unsigned val, int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

    function automatic int unsigned default_dur(int unsigned road, int unsigned light,
                                                int unsigned count_max);
        int unsigned dur;
        case (light)
            0:       dur = DefaultDur0;
            1:       dur = (road % 2 == 1) ? DefaultDur1Odd : DefaultDur1Even;
            2:       dur = DefaultDur2;
            3:       dur = DefaultDur3;
            4:       dur = DefaultDur4;
            default: dur = count_max;
        endcase
        return saturate(dur, count_max);
    endfunction

endpackage

// File: rtl/timing_table.sv
// Per-road, per-phase duration table: reset defaults, saturating writes, asynchronous read.
module timing_table
    import phase_timer_pkg::*;
#(
    parameter int unsigned ROADS     = 4,
    parameter int unsigned LIGHTS    = 5,
    parameter int unsigned COUNT_MAX = 15,
    localparam int unsigned RW = idx_width(ROADS),
    localparam int unsigned LW = idx_width(LIGHTS),
    localparam int unsigned CW = cnt_width(COUNT_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_road,
    input  logic [LW-1:0] wr_light,
    input  logic [CW-1:0] wr_data,
    output logic          wr_err,
    input  logic [RW-1:0] rd_road,
    input  logic [LW-1:0] rd_light,
    output logic [CW-1:0] rd_data
);

    logic [CW-1:0] mem_q [ROADS][LIGHTS];
    logic          wr_idx_ok;
    logic          rd_idx_ok;
    logic [CW-1:0] wr_sat;

    assign wr_idx_ok = in_range(32'(wr_road), ROADS) && in_range(32'(wr_light), LIGHTS);
    assign rd_idx_ok = in_range(32'(rd_road), ROADS) && in_range(32'(rd_light), LIGHTS);
    assign wr_err    = wr_en && !wr_idx_ok;
    assign wr_sat    = CW'(saturate(32'(wr_data), COUNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < ROADS; r++) begin
                for (int unsigned l = 0; l < LIGHTS; l++) begin
                    mem_q[r][l] <= CW'(default_dur(r, l, COUNT_MAX));
                end
            end
        end else if (wr_en && wr_idx_ok) begin
            mem_q[wr_road][wr_light] <= wr_sat;
        end
    end

    // Out-of-range reads never reach the FSM as a load, but keep them deterministic.
    assign rd_data = rd_idx_ok ? mem_q[rd_road][rd_light] : '0;

endmodule

// File: rtl/phase_timer.sv
// Times one traffic-light phase at a time, loading its duration from a programmable table.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int unsigned ROADS     = 4,
    parameter int unsigned LIGHTS    = 5,
    parameter int unsigned COUNT_MAX = 15,
    localparam int unsigned RW = idx_width(ROADS),
    localparam int unsigned LW = idx_width(LIGHTS),
    localparam int unsigned CW = cnt_width(COUNT_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_road,
    input  logic [LW-1:0] wr_light,
    input  logic [CW-1:0] wr_data,
    input  logic          start,
    input  logic [RW-1:0] road,
    input  logic [LW-1:0] light,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] remaining,
    output logic          err
);

    state_e        state_q;
    logic [CW-1:0] entry;
    logic          wr_err;
    logic          start_ok;

    timing_table #(
        .ROADS     (ROADS),
        .LIGHTS    (LIGHTS),
        .COUNT_MAX (COUNT_MAX)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_road  (wr_road),
        .wr_light (wr_light),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .rd_road  (road),
        .rd_light (light),
        .rd_data  (entry)
    );

    assign start_ok = in_range(32'(road), ROADS) && in_range(32'(light), LIGHTS);

    // The table read is pre-edge, so a same-edge write to the started entry loads the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            err  <= wr_err || (state_q == StIdle && start && !start_ok);
            unique case (state_q)
                StIdle: begin
                    if (start && start_ok) begin
                        remaining <= entry;
                        busy      <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (remaining == '0) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StExpire;
                    end else if (tick) begin
                        remaining <= remaining - CW'(1);
                    end
                end
                StExpire: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// Randomised scoreboard bench for phase_timer checked against a table-level reference model.
module tb_phase_timer;

    localparam int ROADS     = 4;
    localparam int LIGHTS    = 5;
    localparam int COUNT_MAX = 15;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, wr_en, start;
    logic [1:0] wr_road, road;
    logic [2:0] wr_light, light;
    logic [3:0] wr_data, remaining;
    logic       busy, done, err;

    logic       tick2, wr_en2, start2;
    logic [1:0] wr_road2, road2;
    logic [2:0] wr_light2, light2;
    logic [3:0] wr_data2, remaining2;
    logic       busy2, done2, err2;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    int   model [ROADS][LIGHTS];
    int   even_d [5] = '{2, 13, 2, 1, 1};
    int   odd_d  [5] = '{2, 5, 2, 1, 1};
    exp_t load_q [$];
    int   done_q [$];
    int   err_q  [$];

    phase_timer #(.ROADS(4), .LIGHTS(5), .COUNT_MAX(15)) dut (
        .clk (clk), .rst (rst), .tick (tick),
        .wr_en (wr_en), .wr_road (wr_road), .wr_light (wr_light), .wr_data (wr_data),
        .start (start), .road (road), .light (light),
        .busy (busy), .done (done), .remaining (remaining), .err (err)
    );

    // Three roads make an out-of-range road encodable; COUNT_MAX 12 makes saturation reachable.
    phase_timer #(.ROADS(3), .LIGHTS(5), .COUNT_MAX(12)) dut2 (
        .clk (clk), .rst (rst), .tick (tick2),
        .wr_en (wr_en2), .wr_road (wr_road2), .wr_light (wr_light2), .wr_data (wr_data2),
        .start (start2), .road (road2), .light (light2),
        .busy (busy2), .done (done2), .remaining (remaining2), .err (err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROADS; r++) begin
            for (int l = 0; l < LIGHTS; l++) begin
                model[r][l] = (l >= 5) ? COUNT_MAX : ((r % 2 == 1) ? odd_d[l] : even_d[l]);
            end
        end
    endtask

    task automatic drive_write(input int r, input int l, input int d, output bit bad);
        wr_en    = 1'b1;
        wr_road  = 2'(r);
        wr_light = 3'(l);
        wr_data  = 4'(d);
        bad      = !(r < ROADS && l < LIGHTS);
        if (!bad) model[r][l] = (d > COUNT_MAX) ? COUNT_MAX : d;
    endtask

    // wr_mode: 0 none, 1 same entry on the start edge, 2 random entry on the start edge.
    task automatic do_txn(input int r, input int l, input int wr_mode, input int tick_pct,
                          input bit noise);
        int acc, n, done_e, idx;
        bit bad_s, bad_w;
        bit plan [$];
        acc   = cyc + 1;
        start = 1'b1;
        road  = 2'(r);
        light = 3'(l);
        tick  = ($urandom_range(0, 1) != 0);
        bad_s = !(r < ROADS && l < LIGHTS);
        n     = 0;
        if (!bad_s) n = model[r][l];
        bad_w = 1'b0;
        if (wr_mode == 1) drive_write(r, l, $urandom_range(0, 15), bad_w);
        else if (wr_mode == 2)
            drive_write($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15), bad_w);
        else wr_en = 1'b0;
        if (bad_s || bad_w) err_q.push_back(acc);
        if (!bad_s) load_q.push_back('{acc, n});
        step();
        start = 1'b0;
        wr_en = 1'b0;
        if (bad_s) return;
        // Ticks from the edge after acceptance count down; done follows the edge seeing zero.
        done_e = acc + 1;
        begin
            int cnt;
            cnt = 0;
            while (cnt < n) begin
                plan.push_back($urandom_range(1, 100) <= tick_pct);
                if (plan[$]) cnt++;
            end
        end
        if (n > 0) done_e = acc + plan.size() + 1;
        done_q.push_back(done_e);
        for (int e = acc + 1; e <= done_e + 1; e++) begin
            idx  = e - acc - 1;
            tick = (idx < plan.size()) ? plan[idx] : ($urandom_range(0, 1) != 0);
            if (noise && $urandom_range(0, 4) == 0) begin
                start = 1'b1;
                road  = 2'($urandom_range(0, 3));
                light = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            bad_w = 1'b0;
            if (noise && $urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) != 0) drive_write(r, l, $urandom_range(0, 15), bad_w);
                else drive_write($urandom_range(0, 3), $urandom_range(0, 7),
                                 $urandom_range(0, 15), bad_w);
            end else begin
                wr_en = 1'b0;
            end
            if (bad_w) err_q.push_back(e);
            step();
        end
        start = 1'b0;
        wr_en = 1'b0;
        tick  = 1'b0;
    endtask

    initial begin
        exp_t x;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (load_q.size() > 0 && load_q[0].cyc == cyc) begin
                x = load_q.pop_front();
                check("load_remaining", 32'(remaining), x.val);
                check("load_busy", 32'(busy), 1);
            end
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
                check("done_pulse", 32'(done), 1);
                check("done_busy", 32'(busy), 0);
                check("done_remaining", 32'(remaining), 0);
            end else if (done) begin
                check("unexpected_done", 32'(done), 0);
            end
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                void'(err_q.pop_front());
                check("err_pulse", 32'(err), 1);
            end else if (err) begin
                check("unexpected_err", 32'(err), 0);
            end
        end
    end

    initial begin
        bit bw;
        rst = 1'b1;
        {tick, wr_en, start, wr_road, road, wr_light, light, wr_data} = '0;
        {tick2, wr_en2, start2, wr_road2, road2, wr_light2, light2, wr_data2} = '0;
        model_reset();
        repeat (2) step();
        @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        check("reset_remaining", 32'(remaining), 0);
        check("dut2_reset_busy", 32'(busy2), 0);
        step();
        rst    = 1'b0;
        mon_en = 1'b1;

        do_txn(0, 1, 0, 100, 1'b0);
        do_txn(3, 1, 0, 34, 1'b0);
        drive_write(1, 0, 0, bw);
        step();
        wr_en = 1'b0;
        do_txn(1, 0, 0, 100, 1'b0);
        do_txn(3, 3, 1, 100, 1'b0);
        do_txn(0, 5, 0, 100, 1'b0);
        @(negedge clk);
        check("bad_start_busy", 32'(busy), 0);
        check("bad_start_remaining", 32'(remaining), 0);
        step();

        repeat (40) begin
            do_txn($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 2),
                   $urandom_range(20, 100), 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end

        // Abort a countdown at remaining 7; the edited entry must return to its default.
        drive_write(2, 1, 9, bw);
        step();
        wr_en = 1'b0;
        load_q.push_back('{cyc + 1, 9});
        start = 1'b1;
        road  = 2'd2;
        light = 3'd1;
        step();
        start = 1'b0;
        tick  = 1'b1;
        repeat (2) step();
        tick = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        check("pre_abort_remaining", 32'(remaining), 7);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_remaining", 32'(remaining), 0);
        check("abort_done", 32'(done), 0);
        model_reset();
        step();
        do_txn(2, 1, 0, 100, 1'b0);

        start2 = 1'b1;
        road2  = 2'd3;
        light2 = 3'd0;
        step();
        start2 = 1'b0;
        @(negedge clk);
        check("dut2_bad_road_err", 32'(err2), 1);
        check("dut2_bad_road_busy", 32'(busy2), 0);
        step();
        wr_en2    = 1'b1;
        wr_road2  = 2'd1;
        wr_light2 = 3'd0;
        wr_data2  = 4'd14;
        step();
        wr_en2 = 1'b0;
        start2 = 1'b1;
        road2  = 2'd1;
        light2 = 3'd0;
        step();
        start2 = 1'b0;
        @(negedge clk);
        check("dut2_saturated_load", 32'(remaining2), 12);
        check("dut2_saturated_busy", 32'(busy2), 1);

        repeat (5) step();
        check("queues_drained", load_q.size() + done_q.size() + err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
